// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register and next-PC selector for the MIPS fetch stage.
// Each cycle the PC loads the adder's PC+4 result or a control-flow redirect
// target (jr > j > br). A stall holds the PC. A redirect that arrives during a
// stall is buffered in pend_pc and applied when the stall drops.
//
// Optional feature (macro FETCH_EXC_VECTOR_EN):
//   Adds the input exc_req and the parameter EXC_VECTOR. exc_req has the
//   highest priority and ignores stall. It loads EXC_VECTOR, clears the
//   buffered redirect and returns the FSM to RUN.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   EXC_VECTOR  exception entry address (only with FETCH_EXC_VECTOR_EN)
//
// Ports:
//   clk               in   1   system clock, rising edge
//   rst_n             in   1   asynchronous active-low reset
//   stall             in   1   hold PC this cycle
//   add4_in           in  32   PC+4 from the adder stage
//   br_taken/target   in 1/32  branch redirect
//   j_taken/target    in 1/32  j/jal redirect
//   jr_taken/target   in 1/32  jr/jalr redirect
//   exc_req           in   1   exception request (FETCH_EXC_VECTOR_EN only)
//   pc_out            out 32   current PC
//   pc_misalign       out  1   registered, pc_out[1:0] != 0
//   redirect_pending  out  1   high while the FSM is in PEND
//
// Handshake note: there is no valid/ready pairing here. A redirect request is
// accepted in the cycle it is high. It is either consumed at once (no stall)
// or captured into pend_pc (stall). The requester never needs to hold it.
//
// FSM state is observable through redirect_pending, which is 1 exactly in PEND.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef FETCH_EXC_VECTOR_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] add4_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_taken,
    input  logic [31:0] j_target,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
`ifdef FETCH_EXC_VECTOR_EN
    input  logic        exc_req,
`endif
    output logic [31:0] pc_out,
    output logic        pc_misalign,
    output logic        redirect_pending
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        misalign_q, misalign_d;
    logic        pc_load;

    logic        redirect;
    logic [31:0] sel_target;

    // Redirect target selection: jr beats j, and j beats br.
    always_comb begin
        redirect   = jr_taken | j_taken | br_taken;
        sel_target = br_target;
        if (jr_taken) begin
            sel_target = jr_target;
        end else if (j_taken) begin
            sel_target = j_target;
        end
    end

    // State register (process 1 of 3)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state and next-PC logic (process 2 of 3)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        pc_load = 1'b0;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_load = 1'b1;
                    pc_d    = redirect ? sel_target : add4_in;
                end else if (redirect) begin
                    pend_d  = sel_target;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!stall) begin
                    // A same-cycle redirect is younger than the buffered one.
                    pc_load = 1'b1;
                    pc_d    = redirect ? sel_target : pend_q;
                    state_d = RUN;
                end else if (redirect) begin
                    // Latest redirect during a stall wins.
                    pend_d = sel_target;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // The misalign flag follows each PC load and holds otherwise.
        misalign_d = pc_load ? (pc_d[1:0] != 2'b00) : misalign_q;

`ifdef FETCH_EXC_VECTOR_EN
        // An exception overrides everything, including a stall.
        if (exc_req) begin
            pc_d       = EXC_VECTOR;
            pend_d     = 32'h0;
            state_d    = RUN;
            misalign_d = 1'b0;
        end
`endif
    end

    // Outputs (process 3 of 3)
    always_comb begin
        pc_out           = pc_q;
        pc_misalign      = misalign_q;
        redirect_pending = (state_q == PEND);
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed steps followed by random traffic for pc_fetch_unit. Expected PC
// values come from a small model. The model keeps the PC, a "redirect buffered"
// flag and the buffered target, and it applies the fetch rules directly.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        stall;
    logic [31:0] add4_in;
    logic        br_taken, j_taken, jr_taken;
    logic [31:0] br_target, j_target, jr_target;
`ifdef FETCH_EXC_VECTOR_EN
    logic        exc_req;
`endif
    logic [31:0] pc_out;
    logic        pc_misalign;
    logic        redirect_pending;

    pc_fetch_unit #(
        .RESET_PC(RESET_PC)
`ifdef FETCH_EXC_VECTOR_EN
        ,
        .EXC_VECTOR(EXC_VECTOR)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .add4_in          (add4_in),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .j_taken          (j_taken),
        .j_target         (j_target),
        .jr_taken         (jr_taken),
        .jr_target        (jr_target),
`ifdef FETCH_EXC_VECTOR_EN
        .exc_req          (exc_req),
`endif
        .pc_out           (pc_out),
        .pc_misalign      (pc_misalign),
        .redirect_pending (redirect_pending)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_buf_valid;
    logic [31:0] m_buf_pc;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_buf_valid = 0;
        m_buf_pc    = 32'h0;
    endtask

    // One clock edge's effect, taken from the fetch rules.
    task automatic model_step(input bit s, input bit b, input logic [31:0] bt,
                              input bit j, input logic [31:0] jt,
                              input bit r, input logic [31:0] rt,
                              input logic [31:0] a4, input bit e);
        bit          any;
        logic [31:0] tgt;
        any = b | j | r;
        tgt = r ? rt : (j ? jt : bt);
        if (e) begin
            m_pc        = EXC_VECTOR;
            m_buf_valid = 0;
        end else if (!s) begin
            if (any)              m_pc = tgt;
            else if (m_buf_valid) m_pc = m_buf_pc;
            else                  m_pc = a4;
            m_buf_valid = 0;
        end else if (any) begin
            m_buf_valid = 1;
            m_buf_pc    = tgt;
        end
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check_outputs(input string tag);
        logic [31:0] exp_pc;
        logic        exp_mis;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard queue empty, pc_out=%h", tag, pc_out);
            return;
        end
        exp_pc  = exp_q.pop_front();
        exp_mis = (exp_pc[1:0] != 2'b00);
        total++;
        assert (pc_out === exp_pc) else begin
            bad++;
            $error("FAIL %s pc_out: got %h want %h", tag, pc_out, exp_pc);
        end
        total++;
        assert (pc_misalign === exp_mis) else begin
            bad++;
            $error("FAIL %s pc_misalign: got %b want %b", tag, pc_misalign, exp_mis);
        end
        total++;
        assert (redirect_pending === m_buf_valid) else begin
            bad++;
            $error("FAIL %s redirect_pending: got %b want %b", tag, redirect_pending, m_buf_valid);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input string tag, input bit s,
                       input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt,
                       input bit r, input logic [31:0] rt,
                       input logic [31:0] a4);
        bit e;
        e = 0;
        @(negedge clk);
        stall     = s;
        br_taken  = b;  br_target = bt;
        j_taken   = j;  j_target  = jt;
        jr_taken  = r;  jr_target = rt;
        add4_in   = a4;
`ifdef FETCH_EXC_VECTOR_EN
        e = exc_req;
`endif
        model_step(s, b, bt, j, jt, r, rt, a4, e);
        exp_q.push_back(m_pc);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Plain sequential step: no stall, no redirect, add4 = model PC + 4.
    task automatic step4(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, m_pc + 32'd4);
    endtask

    // Reset pulse between clock edges, checked while still in reset.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(m_pc);
        #1;
        check_outputs(tag);
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        stall = 0; add4_in = 0;
        br_taken = 0; j_taken = 0; jr_taken = 0;
        br_target = 0; j_target = 0; jr_target = 0;
`ifdef FETCH_EXC_VECTOR_EN
        exc_req = 0;
`endif
        model_reset();
        #12;
        exp_q.push_back(m_pc);
        check_outputs("reset");
        #2 rst_n = 1'b1;

        // Sequential fetch 0x3004..0x3010.
        for (int i = 0; i < 4; i++) step4("seq");

        // Stall three cycles with jr buffered in the first one.
        cyc("stall_jr",  1, 0, 0, 0, 0, 1, 32'h3400, m_pc + 4);
        cyc("stall_2",   1, 0, 0, 0, 0, 0, 0, m_pc + 4);
        cyc("stall_3",   1, 0, 0, 0, 0, 0, 0, m_pc + 4);
        cyc("pend_rel",  0, 0, 0, 0, 0, 0, 0, m_pc + 4);

        // Same-cycle redirect beats the buffered target.
        cyc("pend_set",  1, 0, 0, 0, 0, 1, 32'h3400, m_pc + 4);
        cyc("pend_br",   0, 1, 32'h3500, 0, 0, 0, 0, m_pc + 4);

        // Priority: j beats br, and jr beats j.
        cyc("goto3008",  0, 0, 0, 1, 32'h3008, 0, 0, m_pc + 4);
        cyc("j_vs_br",   0, 1, 32'h3100, 1, 32'h3200, 0, 0, m_pc + 4);
        cyc("jr_vs_all", 0, 1, 32'h3100, 1, 32'h3200, 1, 32'h3300, m_pc + 4);

        // Latest buffered redirect wins.
        cyc("pend_a",    1, 1, 32'h3600, 0, 0, 0, 0, m_pc + 4);
        cyc("pend_b",    1, 0, 0, 1, 32'h3700, 0, 0, m_pc + 4);
        cyc("pend_b_ld", 0, 0, 0, 0, 0, 0, 0, m_pc + 4);

        // Misaligned target, then realignment.
        cyc("mis_j",     0, 0, 0, 1, 32'h3002, 0, 0, m_pc + 4);
        cyc("mis_hold",  1, 0, 0, 0, 0, 0, 0, 32'h3004);
        cyc("mis_clr",   0, 0, 0, 0, 0, 0, 0, 32'h3004);

        // Wrap-around.
        cyc("to_top",    0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, m_pc + 4);
        step4("wrap");

        // Asynchronous reset in the middle of PEND discards the buffer.
        cyc("pre_rst",   1, 0, 0, 0, 0, 1, 32'h3900, m_pc + 4);
        async_reset("rst_mid_pend");
        step4("post_rst");

`ifdef FETCH_EXC_VECTOR_EN
        cyc("exc_pend",  1, 0, 0, 0, 0, 1, 32'h3A00, m_pc + 4);
        exc_req = 1;
        cyc("exc_stall", 1, 0, 0, 0, 0, 0, 0, m_pc + 4);
        exc_req = 0;
        step4("post_exc");
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bit          s, b, j, r;
            logic [31:0] bt, jt, rt;
            s  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            bt = $urandom();
            jt = $urandom();
            rt = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                bt[1:0] = 2'b00; jt[1:0] = 2'b00; rt[1:0] = 2'b00;
            end
`ifdef FETCH_EXC_VECTOR_EN
            exc_req = ($urandom_range(0, 30) == 0);
`endif
            cyc("rand", s, b, bt, j, jt, r, rt, m_pc + 4);
`ifdef FETCH_EXC_VECTOR_EN
            exc_req = 0;
`endif
            if ($urandom_range(0, 60) == 0) async_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
